// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver.
// Holds parity-mode encodings, the receiver state encoding, the oversample
// ratio with its majority-vote sample indices, and the 3-input majority helper.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned SMP_W      = $clog2(OVERSAMPLE);

  // Tick numbers within a bit at which the line is sampled; decision at the last.
  localparam logic [SMP_W-1:0] SMP_A = SMP_W'(7);
  localparam logic [SMP_W-1:0] SMP_B = SMP_W'(8);
  localparam logic [SMP_W-1:0] SMP_C = SMP_W'(9);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Received-word stream between the UART receiver and its consumer.
// master (receiver): rx_data, rx_valid, parity_err, frame_err, break_det, overrun out; rx_ready in.
// slave (consumer):  the reverse.
interface uart_rx_os_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 break_det;
  logic                 overrun;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, break_det, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, break_det, overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_os_tick.sv
// Prescaled oversample tick generator with synchronous restart.
// Ports: CLK, rst (sync, active-high), restart (zero the counter),
//        prescaler (CLK cycles per tick, 0 treated as 1), tick_c (1-cycle tick).
module uart_os_tick #(
  parameter int unsigned PRESCALER_W = 21
) (
  input  logic                   CLK,
  input  logic                   rst,
  input  logic                   restart,
  input  logic [PRESCALER_W-1:0] prescaler,
  output logic                   tick_c
);

  logic [PRESCALER_W-1:0] cnt_q;
  logic [PRESCALER_W-1:0] lim_c;

  // Terminal count is effective prescaler minus one; 0 and 1 both tick every cycle.
  assign lim_c  = (prescaler == '0) ? '0 : PRESCALER_W'(prescaler - 1'b1);
  assign tick_c = (cnt_q == lim_c);

  always_ff @(posedge CLK) begin
    if (rst || restart) begin
      cnt_q <= '0;
    end else if (tick_c) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= PRESCALER_W'(cnt_q + 1'b1);
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampling UART receiver, 5..9 data bits, optional parity, 1/2 stop bits.
// Ports: CLK, rst (sync, active-high), RX (async serial in, idle high),
//        prescaler_in (CLK cycles per oversample tick), parity_mode, two_stop,
//        rx_if (master: received word, valid/ready, error flags, pulses).
// Build option: define UART_RX_PARITY_EN to include parity bit handling;
// without it parity_mode is ignored and parity_err is always 0.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PRESCALER_W = 21
) (
  input  logic                   CLK,
  input  logic                   rst,
  input  logic                   RX,
  input  logic [PRESCALER_W-1:0] prescaler_in,
  input  logic [1:0]             parity_mode,
  input  logic                   two_stop,
  uart_rx_os_if.master           rx_if
);

  localparam int unsigned BITCNT_W = 4;

  logic [2:0]             sync_q;
  logic                   rxs;
  logic                   rxs_q;
  logic                   fall_c;
  rx_state_e              state;
  logic [PRESCALER_W-1:0] presc_q;
  logic                   two_stop_q;
  logic                   tick_c;
  logic [SMP_W-1:0]       scnt;
  logic [SMP_W-1:0]       scnt_nx_c;
  logic                   smp_a;
  logic                   smp_b;
  logic                   bit_c;
  logic [DATA_BITS-1:0]   shift_q;
  logic [BITCNT_W-1:0]    bit_cnt;
  logic                   stop_idx;
  logic                   f_ferr;
  logic                   f_brk;
  logic                   done_q;

  logic [DATA_BITS-1:0]   rx_data_q;
  logic                   rx_valid_q;
  logic                   ferr_q;
  logic                   brk_q;
  logic                   ovr_q;

`ifdef UART_RX_PARITY_EN
  logic [1:0]             par_q;
  logic                   par_en_c;
  logic                   par_err_c;
  logic                   f_perr;
  logic                   perr_q;

  assign par_en_c  = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
  // Even: data XOR must equal the parity bit; odd: it must differ.
  assign par_err_c = (par_q == PAR_ODD) ? ((^shift_q) == bit_c) : ((^shift_q) != bit_c);
`else
  logic                   unused_cfg;
  assign unused_cfg = ^parity_mode;
`endif

  assign rxs       = sync_q[2];
  assign fall_c    = rxs_q & ~rxs;
  assign scnt_nx_c = SMP_W'(scnt + 1'b1);
  assign bit_c     = maj3(smp_a, smp_b, rxs);

  uart_os_tick #(.PRESCALER_W(PRESCALER_W)) u_tick (
    .CLK       (CLK),
    .rst       (rst),
    .restart   ((state == ST_IDLE) && fall_c),
    .prescaler (presc_q),
    .tick_c    (tick_c)
  );

  // Synchroniser, sampling and frame FSM; done_q marks the last stop decision.
  always_ff @(posedge CLK) begin
    if (rst) begin
      sync_q     <= 3'b111;
      rxs_q      <= 1'b1;
      state      <= ST_IDLE;
      presc_q    <= '0;
      two_stop_q <= 1'b0;
      scnt       <= '0;
      smp_a      <= 1'b1;
      smp_b      <= 1'b1;
      shift_q    <= '0;
      bit_cnt    <= '0;
      stop_idx   <= 1'b0;
      f_ferr     <= 1'b0;
      f_brk      <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q      <= PAR_NONE;
      f_perr     <= 1'b0;
`endif
    end else begin
      sync_q <= {sync_q[1:0], RX};
      rxs_q  <= rxs;
      done_q <= 1'b0;
      if (state == ST_IDLE) begin
        if (fall_c) begin
          state      <= ST_START;
          presc_q    <= prescaler_in;
          two_stop_q <= two_stop;
          scnt       <= '0;
          bit_cnt    <= '0;
          stop_idx   <= 1'b0;
          f_ferr     <= 1'b0;
          f_brk      <= 1'b0;
`ifdef UART_RX_PARITY_EN
          par_q      <= parity_mode;
          f_perr     <= 1'b0;
`endif
        end
      end else if (tick_c) begin
        scnt <= scnt_nx_c;
        if (scnt_nx_c == SMP_A) smp_a <= rxs;
        if (scnt_nx_c == SMP_B) smp_b <= rxs;
        if (scnt_nx_c == SMP_C) begin
          case (state)
            ST_START: state <= bit_c ? ST_IDLE : ST_DATA;
            ST_DATA: begin
              shift_q <= {bit_c, shift_q[DATA_BITS-1:1]};
              bit_cnt <= BITCNT_W'(bit_cnt + 1'b1);
              if (bit_cnt == BITCNT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                state <= par_en_c ? ST_PARITY : ST_STOP;
`else
                state <= ST_STOP;
`endif
              end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
              f_perr <= par_err_c;
              state  <= ST_STOP;
            end
`endif
            ST_STOP: begin
              if (!bit_c) f_ferr <= 1'b1;
              if (!stop_idx) f_brk <= ~bit_c & ~(|shift_q);
              // Leaving at mid-bit keeps the next start edge catchable.
              if (stop_idx || !two_stop_q) begin
                state  <= ST_IDLE;
                done_q <= 1'b1;
              end else begin
                stop_idx <= 1'b1;
              end
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

  // One-entry holding register; a full, unaccepted register drops the new frame.
  always_ff @(posedge CLK) begin
    if (rst) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q     <= 1'b0;
`endif
    end else begin
      brk_q <= 1'b0;
      ovr_q <= 1'b0;
      if (rx_valid_q && rx_if.rx_ready) rx_valid_q <= 1'b0;
      if (done_q) begin
        brk_q <= f_brk;
        if (!rx_valid_q || rx_if.rx_ready) begin
          rx_data_q  <= shift_q;
          rx_valid_q <= 1'b1;
          ferr_q     <= f_ferr;
`ifdef UART_RX_PARITY_EN
          perr_q     <= f_perr;
`endif
        end else begin
          ovr_q <= 1'b1;
        end
      end
    end
  end

  assign rx_if.rx_data   = rx_data_q;
  assign rx_if.rx_valid  = rx_valid_q;
  assign rx_if.frame_err = ferr_q;
  assign rx_if.break_det = brk_q;
  assign rx_if.overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign rx_if.parity_err = perr_q;
`else
  assign rx_if.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed self-checking bench for uart_rx_os (prescaler 4, bit = 64 CLK).
module tb_uart_rx_os;

  localparam int P   = 4;
  localparam int BIT = 16 * P;

  logic        CLK;
  logic        rst;
  logic        RX;
  logic [20:0] prescaler_in;
  logic [1:0]  parity_mode;
  logic        two_stop;

  uart_rx_os_if #(.DATA_BITS(8)) rx_if ();

  uart_rx_os #(.DATA_BITS(8), .PRESCALER_W(21)) dut (
    .CLK          (CLK),
    .rst          (rst),
    .RX           (RX),
    .prescaler_in (prescaler_in),
    .parity_mode  (parity_mode),
    .two_stop     (two_stop),
    .rx_if        (rx_if)
  );

  int tests = 0;
  int fails = 0;
  int ovr_cnt = 0;
  int brk_cnt = 0;
  int vld_rise = 0;
  logic vld_prev = 1'b0;

  logic       got_v;
  int         lat_v;
  logic [7:0] s_data;
  logic       s_perr;
  logic       s_ferr;
  int         o0, b0, v0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (rx_if.overrun) ovr_cnt++;
    if (rx_if.break_det) brk_cnt++;
    if (rx_if.rx_valid && !vld_prev) vld_rise++;
    vld_prev = rx_if.rx_valid;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame bits LSB first: start, 8 data, stop1, stop2, then idle ones.
  function automatic logic [15:0] f8n(input logic [7:0] d, input logic s1, input logic s2);
    return {5'b11111, s2, s1, d, 1'b0};
  endfunction

  function automatic logic [15:0] f8p(input logic [7:0] d, input logic p);
    return {5'b11111, 1'b1, p, d, 1'b0};
  endfunction

  // Called just after a rising edge; optional 4-CLK inversion covering sample 8 of bit gbit.
  task automatic send_bits(input logic [15:0] bits, input int n, input int gbit);
    for (int b = 0; b < n; b++) begin
      RX = bits[b];
      if (b == gbit) begin
        repeat (31) @(posedge CLK);
        #1 RX = ~bits[b];
        repeat (4) @(posedge CLK);
        #1 RX = bits[b];
        repeat (BIT - 35) @(posedge CLK);
        #1;
      end else begin
        repeat (BIT) @(posedge CLK);
        #1;
      end
    end
    RX = 1'b1;
  endtask

  // Sends a frame and records the first rx_valid with its latency from the start edge.
  task automatic run_frame(input logic [15:0] bits, input int n, input int gbit);
    got_v = 1'b0;
    lat_v = 0;
    fork
      begin
        @(posedge CLK);
        #1;
        send_bits(bits, n, gbit);
      end
      begin
        @(posedge CLK);
        for (int c = 1; c <= n * BIT + 100 && !got_v; c++) begin
          @(posedge CLK);
          #1;
          if (rx_if.rx_valid) begin
            got_v  = 1'b1;
            lat_v  = c;
            s_data = rx_if.rx_data;
            s_perr = rx_if.parity_err;
            s_ferr = rx_if.frame_err;
          end
        end
      end
    join
    repeat (BIT) @(posedge CLK);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    RX = 1'b1;
    prescaler_in = 21'(P);
    parity_mode = 2'b00;
    two_stop = 1'b0;
    rx_if.rx_ready = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    check("rst_valid", 32'(rx_if.rx_valid), 32'd0);
    check("rst_data", 32'(rx_if.rx_data), 32'd0);
    check("rst_perr", 32'(rx_if.parity_err), 32'd0);
    check("rst_ferr", 32'(rx_if.frame_err), 32'd0);
    check("rst_brk", 32'(rx_if.break_det), 32'd0);
    check("rst_ovr", 32'(rx_if.overrun), 32'd0);
    rst = 1'b0;
    repeat (5) @(posedge CLK);
    #1;

    // 8N1 0xA5: latency 4 + 9.5625*64 + 1 = 617
    run_frame(f8n(8'hA5, 1'b1, 1'b1), 10, -1);
    check("a5_got", 32'(got_v), 32'd1);
    check("a5_lat", 32'(lat_v), 32'd617);
    check("a5_data", 32'(s_data), 32'hA5);
    check("a5_perr", 32'(s_perr), 32'd0);
    check("a5_ferr", 32'(s_ferr), 32'd0);

`ifdef UART_RX_PARITY_EN
    // 8E1 0x41 (two ones): parity bit 1 is wrong, 0 is right; latency 681
    parity_mode = 2'b01;
    run_frame(f8p(8'h41, 1'b1), 11, -1);
    check("even_bad_data", 32'(s_data), 32'h41);
    check("even_bad_perr", 32'(s_perr), 32'd1);
    check("even_bad_lat", 32'(lat_v), 32'd681);
    run_frame(f8p(8'h41, 1'b0), 11, -1);
    check("even_ok_perr", 32'(s_perr), 32'd0);
    check("even_ok_ferr", 32'(s_ferr), 32'd0);
    parity_mode = 2'b10;
    run_frame(f8p(8'h41, 1'b0), 11, -1);
    check("odd_bad_perr", 32'(s_perr), 32'd1);
`else
    // Parity build option off: parity_mode ignored, frame is plain 8N1
    parity_mode = 2'b01;
    run_frame(f8n(8'hC3, 1'b1, 1'b1), 10, -1);
    check("nopar_data", 32'(s_data), 32'hC3);
    check("nopar_lat", 32'(lat_v), 32'd617);
    check("nopar_perr", 32'(s_perr), 32'd0);
`endif
    parity_mode = 2'b00;

    // 8N2 with second stop 0: frame error, latency 681
    two_stop = 1'b1;
    run_frame(f8n(8'h3C, 1'b1, 1'b0), 11, -1);
    check("n2_data", 32'(s_data), 32'h3C);
    check("n2_ferr", 32'(s_ferr), 32'd1);
    check("n2_lat", 32'(lat_v), 32'd681);

    // Line held low 12 bit times: break
    b0 = brk_cnt;
    run_frame(16'h0000, 12, -1);
    check("brk_got", 32'(got_v), 32'd1);
    check("brk_data", 32'(s_data), 32'h00);
    check("brk_ferr", 32'(s_ferr), 32'd1);
    check("brk_pulse", 32'(brk_cnt - b0), 32'd1);
    two_stop = 1'b0;

    // Short low glitches are false starts
    v0 = vld_rise;
    b0 = brk_cnt;
    o0 = ovr_cnt;
    @(posedge CLK);
    #1 RX = 1'b0;
    repeat (P) @(posedge CLK);
    #1 RX = 1'b1;
    repeat (2 * BIT) @(posedge CLK);
    #1 RX = 1'b0;
    repeat (3 * P) @(posedge CLK);
    #1 RX = 1'b1;
    repeat (12 * BIT) @(posedge CLK);
    #1;
    check("glitch_novalid", 32'(vld_rise - v0), 32'd0);
    check("glitch_valid", 32'(rx_if.rx_valid), 32'd0);
    check("glitch_flags", 32'((brk_cnt - b0) + (ovr_cnt - o0)), 32'd0);

    // Single inverted sample inside data bit 3 is outvoted
    run_frame(f8n(8'hFF, 1'b1, 1'b1), 10, 4);
    check("vote_data", 32'(s_data), 32'hFF);
    check("vote_ferr", 32'(s_ferr), 32'd0);

    // Overrun: consumer stalled across two frames
    rx_if.rx_ready = 1'b0;
    o0 = ovr_cnt;
    run_frame(f8n(8'h11, 1'b1, 1'b1), 10, -1);
    check("ovr_first", 32'(s_data), 32'h11);
    @(posedge CLK);
    #1;
    send_bits(f8n(8'h22, 1'b1, 1'b1), 10, -1);
    repeat (10) @(posedge CLK);
    #1;
    check("ovr_pulse", 32'(ovr_cnt - o0), 32'd1);
    check("ovr_held_data", 32'(rx_if.rx_data), 32'h11);
    check("ovr_held_valid", 32'(rx_if.rx_valid), 32'd1);
    fork
      begin
        @(posedge CLK);
        #1;
        send_bits(f8n(8'h33, 1'b1, 1'b1), 10, -1);
      end
      begin
        @(posedge CLK);
        repeat (616) @(posedge CLK);
        #1 rx_if.rx_ready = 1'b1;
        @(posedge CLK);
        #1;
        check("acc_load_data", 32'(rx_if.rx_data), 32'h33);
        check("acc_load_valid", 32'(rx_if.rx_valid), 32'd1);
        check("acc_load_ovr", 32'(rx_if.overrun), 32'd0);
      end
    join
    repeat (BIT) @(posedge CLK);
    #1;
    check("acc_ovr_total", 32'(ovr_cnt - o0), 32'd1);

    // Reset mid-DATA abandons the frame
    v0 = vld_rise;
    fork
      begin
        @(posedge CLK);
        #1;
        send_bits(f8n(8'hFF, 1'b1, 1'b1), 10, -1);
      end
      begin
        @(posedge CLK);
        repeat (200) @(posedge CLK);
        #1 rst = 1'b1;
        repeat (2) @(posedge CLK);
        #1 rst = 1'b0;
      end
    join
    repeat (BIT) @(posedge CLK);
    #1;
    check("rstmid_noout", 32'(vld_rise - v0), 32'd0);
    run_frame(f8n(8'h5A, 1'b1, 1'b1), 10, -1);
    check("rstmid_data", 32'(s_data), 32'h5A);
    check("rstmid_lat", 32'(lat_v), 32'd617);
    check("rstmid_flags", 32'({s_perr, s_ferr}), 32'd0);
    check("rstmid_first", 32'(vld_rise - v0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
